hs32_regfetch: RTL and testbench
================================

Name: hs32_regfetch

Overview:
Operand-fetch sequencer that drives the register file as its initiator. It accepts a read request for one or two source registers from the pipeline and serializes the reads through the file's single registered read port. It forwards a same-edge write-back so no read-during-write race reaches the pipeline, then returns both operands with a valid/ready handshake. Write-back traffic passes straight through to the file's write port.

Parameters:
DATA_WIDTH, 32, register data width
ADDR_WIDTH, 4, register address width (16 registers)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
req_valid  in  1  operand request valid
req_ready  out  1  request accepted when valid&&ready at posedge
req_rs1  in  ADDR_WIDTH  first source register
req_rs2  in  ADDR_WIDTH  second source register
req_two  in  1  1 = fetch rs1 and rs2; 0 = rs1 only
rsp_valid  out  1  operands valid
rsp_ready  in  1  consumer accepts operands
rsp_a  out  DATA_WIDTH  value of rs1
rsp_b  out  DATA_WIDTH  value of rs2 (0 when req_two=0)
wb_valid  in  1  write-back request (always accepted)
wb_adr  in  ADDR_WIDTH  write-back address
wb_data  in  DATA_WIDTH  write-back data
rf_we  out  1  to register file write enable
rf_wadr  out  ADDR_WIDTH  to register file write address
rf_din  out  DATA_WIDTH  to register file write data
rf_radr  out  ADDR_WIDTH  to register file read address (sampled at posedge)
rf_dout  in  DATA_WIDTH  from register file; valid the cycle after rf_radr sampled

Behaviour:
- Reset (synchronous, clk edge with reset=1): state=IDLE; rsp_valid=0; rsp_a=rsp_b=0; latched rs1/rs2/two and forward flags cleared. While reset=1: req_ready=0, rf_we=0.
- Write path, combinational: rf_we=wb_valid&&!reset, rf_wadr=wb_adr, rf_din=wb_data. No buffering.
- FSM states: IDLE, RD_A, RD_B, CAP_B, RESP.
- IDLE: req_ready=1, rf_radr=0. On req_valid, latch rs1, rs2 and two, then go to RD_A.
- RD_A: rf_radr=rs1. At the edge, record fwd=(wb_valid&&wb_adr==rs1) and fdata=wb_data. Go to RD_B.
- RD_B: rf_radr=rs2. At the edge, rsp_a<=fwd?fdata:rf_dout.
  - If two: record the forward for rs2 as in RD_A and go to CAP_B.
  - Else: rsp_b<=0 and go to RESP.
- CAP_B: rf_radr=0. At the edge, rsp_b<=fwd?fdata:rf_dout. Go to RESP.
- RESP: rsp_valid=1, rf_radr=0. rsp_a/rsp_b are held stable until rsp_valid&&rsp_ready, then go to IDLE.
- req_ready=0 in every state except IDLE. There is one bubble cycle between back-to-back requests.
- Latency from the accept edge to rsp_valid high: two=1 gives 3 cycles; two=0 gives 2 cycles; rsp_ready=1 is assumed.
- Forwarding rule: a write whose edge coincides with the read-sample edge supplies the operand. Writes at earlier edges are already in the file. Writes after the sample edge are not reflected: operands are a snapshot.
- rs1==rs2 is legal; two independent reads occur, each with its own forward check.
- rsp_valid is registered. The state machine ignores req_valid outside IDLE and ignores rsp_ready outside RESP.
- Reset mid-operation aborts the fetch and no response is issued. A write-back during the reset cycle is dropped (rf_we=0).

Test Plan:
- Reset, then idle: rsp_valid=0, rsp_a=rsp_b=0, req_ready=1 one cycle after reset deasserts, rf_we=0 during reset.
- Preload r3=0x11111111 and r7=0x22222222 via wb; request rs1=3, rs2=7, two=1 with rsp_ready=1. Required: rsp_valid exactly 3 cycles after accept, rsp_a=0x11111111, rsp_b=0x22222222.
- Same-edge forward: r5=0xAAAA0000; issue wb r5=0xDEADBEEF coinciding with the RD_A sample edge. Required: rsp_a=0xDEADBEEF, and r5 reads 0xDEADBEEF on the next request.
- One-operand request: rs1=2 (=0x5), two=0. Required: rsp_valid 2 cycles after accept, rsp_a=0x5, rsp_b=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while writing r3=0x99. Required: rsp_valid stays 1, rsp_a keeps its old value, req_ready=0, and the response is released on the first rsp_ready=1.
- Assert reset during CAP_B. Required: no rsp_valid pulse, state IDLE, the next request completes normally with correct data.

Source files
------------

// File: rtl/hs32_regfetch.sv
// hs32 operand fetch: serializes rs1/rs2 reads through the single
// registered read port, forwarding same-edge write-backs.
module hs32_regfetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  req_two,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_a,
  output logic [DATA_WIDTH-1:0] rsp_b,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_adr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wadr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_radr,
  input  logic [DATA_WIDTH-1:0] rf_dout
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_B, CAP_B, RESP
  } state_t;

  state_t state, nxt;

  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
  logic                  two_q, fwd_q;
  logic [DATA_WIDTH-1:0] fdata_q;
  logic [DATA_WIDTH-1:0] operand;
  logic                  hit;

  assign rf_we   = wb_valid && !reset;
  assign rf_wadr = wb_adr;
  assign rf_din  = wb_data;

  // The file returns pre-write data when read and write share an edge.
  assign hit     = wb_valid && (wb_adr == rf_radr);
  assign operand = fwd_q ? fdata_q : rf_dout;

  always_comb begin
    nxt       = state;
    req_ready = 1'b0;
    rf_radr   = '0;
    unique case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) nxt = RD_A;
      end
      RD_A: begin
        rf_radr = rs1_q;
        nxt     = RD_B;
      end
      RD_B: begin
        rf_radr = rs2_q;
        nxt     = two_q ? CAP_B : RESP;
      end
      CAP_B: nxt = RESP;
      RESP: if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      two_q     <= 1'b0;
      fwd_q     <= 1'b0;
      fdata_q   <= '0;
    end else begin
      state     <= nxt;
      rsp_valid <= (nxt == RESP);
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            two_q <= req_two;
          end
        end
        RD_A: begin
          fwd_q   <= hit;
          fdata_q <= wb_data;
        end
        RD_B: begin
          rsp_a <= operand;
          if (two_q) begin
            fwd_q   <= hit;
            fdata_q <= wb_data;
          end else begin
            rsp_b <= '0;
          end
        end
        CAP_B: rsp_b <= operand;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_regfetch.sv
// Bench for hs32_regfetch: register file model, architectural
// reference model, directed scenarios and random traffic.
module tb_hs32_regfetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_two;
  logic [3:0]  req_rs1, req_rs2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_a, rsp_b;
  logic        wb_valid;
  logic [3:0]  wb_adr;
  logic [31:0] wb_data;
  logic        rf_we;
  logic [3:0]  rf_wadr, rf_radr;
  logic [31:0] rf_din, rf_dout;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  hs32_regfetch dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_two(req_two),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b),
    .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
    .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_din(rf_din),
    .rf_radr(rf_radr), .rf_dout(rf_dout)
  );

  always #5 clk = ~clk;

  // Register file: one write port, one registered read port
  // that returns the pre-write contents on a same-edge collision.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (rf_we) mem[rf_wadr] <= rf_din;
    rf_dout <= mem[rf_radr];
  end

  // Reference: architectural register values plus a transaction
  // tracker. rs1 is snapshotted after the 1st edge past accept,
  // rs2 after the 2nd; the response appears 2 (one) or 3 (two) edges in.
  logic [31:0] arch [16];
  bit          m_busy, m_valid, m_two;
  int          m_cnt;
  logic [3:0]  m_rs1, m_rs2;
  logic [31:0] m_a, m_b;

  always @(posedge clk) begin
    if (reset) begin
      m_busy  = 0;
      m_valid = 0;
      m_cnt   = 0;
    end else begin
      if (wb_valid) arch[wb_adr] = wb_data;
      if (m_valid) begin
        if (rsp_ready) m_valid = 0;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == 1) begin
          m_a = arch[m_rs1];
        end else if (m_cnt == 2) begin
          if (m_two) begin
            m_b = arch[m_rs2];
          end else begin
            m_b = 0;
            m_valid = 1;
            m_busy = 0;
          end
        end else begin
          m_valid = 1;
          m_busy = 0;
        end
      end else if (req_valid) begin
        m_busy = 1;
        m_cnt  = 0;
        m_rs1  = req_rs1;
        m_rs2  = req_rs2;
        m_two  = req_two;
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_radr();
    if (m_busy && m_cnt == 0) return m_rs1;
    if (m_busy && m_cnt == 1) return m_rs2;
    return 4'd0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_we", rf_we, wb_valid && !reset);
      chk("rf_wadr", rf_wadr, wb_adr);
      chk("rf_din", rf_din, wb_data);
      chk("req_ready", req_ready, !m_busy && !m_valid && !reset);
      chk("rsp_valid", rsp_valid, m_valid);
      chk("rf_radr", rf_radr, exp_radr());
      if (m_valid) begin
        chk("rsp_a", rsp_a, m_a);
        chk("rsp_b", rsp_b, m_b);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    wb_valid = 1;
    wb_adr   = a;
    wb_data  = d;
    step();
    wb_valid = 0;
  endtask

  task automatic do_req(input logic [3:0] r1, input logic [3:0] r2,
                        input logic two, output int lat);
    req_valid = 1;
    req_rs1   = r1;
    req_rs2   = r2;
    req_two   = two;
    step();
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 0;
      arch[i] = 0;
    end
    reset = 1; req_valid = 0; req_two = 0;
    req_rs1 = 0; req_rs2 = 0; rsp_ready = 1;
    wb_valid = 1; wb_adr = 4'd9; wb_data = 32'hdeadbeef;
    repeat (3) step();
    chk("we_in_reset", rf_we, 1'b0);
    chk("ready_in_reset", req_ready, 1'b0);
    chk_en = 1;
    wb_valid = 0;
    reset = 0;
    step();
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_valid", rsp_valid, 1'b0);
    chk("idle_a", rsp_a, 32'h0);
    chk("idle_b", rsp_b, 32'h0);

    wb_write(4'd3, 32'h11111111);
    wb_write(4'd7, 32'h22222222);
    do_req(4'd3, 4'd7, 1'b1, lat);
    chk("lat_two", lat, 3);
    chk("two_a", rsp_a, 32'h11111111);
    chk("two_b", rsp_b, 32'h22222222);
    step();

    wb_write(4'd5, 32'haaaa0000);
    req_valid = 1; req_rs1 = 4'd5; req_rs2 = 4'd0; req_two = 0;
    step();
    req_valid = 0;
    wb_valid = 1; wb_adr = 4'd5; wb_data = 32'hdeadbeef;
    step();
    wb_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("fwd_valid", rsp_valid, 1'b1);
    chk("fwd_a", rsp_a, 32'hdeadbeef);
    step();
    do_req(4'd5, 4'd0, 1'b0, lat);
    chk("fwd_persist", rsp_a, 32'hdeadbeef);
    step();

    wb_write(4'd2, 32'h5);
    do_req(4'd2, 4'd9, 1'b0, lat);
    chk("lat_one", lat, 2);
    chk("one_a", rsp_a, 32'h5);
    chk("one_b", rsp_b, 32'h0);
    step();

    rsp_ready = 0;
    do_req(4'd3, 4'd7, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1; wb_adr = 4'd3; wb_data = 32'h99;
      step();
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_a", rsp_a, 32'h11111111);
      chk("bp_ready", req_ready, 1'b0);
    end
    wb_valid = 0;
    rsp_ready = 1;
    step();
    chk("bp_release", rsp_valid, 1'b0);

    req_valid = 1; req_rs1 = 4'd7; req_rs2 = 4'd3; req_two = 1;
    step();
    req_valid = 0;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_valid", rsp_valid, 1'b0);
    end
    chk("abort_idle", req_ready, 1'b1);
    do_req(4'd7, 4'd3, 1'b1, lat);
    chk("post_lat", lat, 3);
    chk("post_a", rsp_a, 32'h22222222);
    chk("post_b", rsp_b, 32'h99);
    step();

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(99) == 0);
      req_valid = $urandom_range(1);
      req_rs1   = 4'($urandom_range(15));
      req_rs2   = ($urandom_range(3) == 0) ? req_rs1
                                           : 4'($urandom_range(15));
      req_two   = $urandom_range(1);
      rsp_ready = ($urandom_range(9) < 7);
      wb_valid  = $urandom_range(1);
      wb_adr    = 4'($urandom_range(15));
      wb_data   = $urandom;
      step();
    end
    reset = 0;
    wb_valid = 0;
    req_valid = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
